// File: rtl/pool2d_stream.sv
// 2x2 stride-2 max/average pooling over a raster-order pixel stream.
// Column pairs are reduced on the fly; even-row partials wait in a half-width line buffer.
module pool2d_stream #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 6,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              valid_in,
  input  logic              mode,
  output logic [DATA_W-1:0] o_data,
  output logic              valid_out,
  output logic              frame_done
);

  localparam int CW   = $clog2(IMG_W + 1);
  localparam int RW   = $clog2(IMG_H + 1);
  localparam int NK   = IMG_W / 2;
  localparam int NR   = IMG_H / 2;
  localparam int LB_D = 2 ** (CW - 1);

  typedef logic signed [DATA_W+1:0] ext_t;

  function automatic ext_t ext(input logic [DATA_W-1:0] d);
    ext = (SIGNED != 0) ? {{2{d[DATA_W-1]}}, d} : {2'b00, d};
  endfunction

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              r_mode;
  logic [DATA_W-1:0] r_pair;
  ext_t              r_lb [LB_D];

  logic              w_last_col;
  logic              w_last_row;
  logic [CW-2:0]     w_k;
  ext_t              w_a;
  ext_t              w_b;
  ext_t              w_pair;
  ext_t              w_lb;
  ext_t              w_win;
  logic [DATA_W-1:0] w_res;
  logic              w_out;
  logic              w_fd;

  // All arithmetic in DATA_W+2 signed bits; unsigned inputs are zero-extended so the
  // signed compare stays correct and the 4-pixel sum cannot overflow.
  always_comb begin
    w_last_col = (r_col == CW'(IMG_W - 1));
    w_last_row = (r_row == RW'(IMG_H - 1));
    w_k        = r_col[CW-1:1];
    w_a        = ext(r_pair);
    w_b        = ext(i_data);
    if (r_mode) w_pair = w_a + w_b;
    else        w_pair = (w_b > w_a) ? w_b : w_a;
    w_lb = r_lb[w_k];
    if (r_mode) w_win = w_lb + w_pair;
    else        w_win = (w_pair > w_lb) ? w_pair : w_lb;
    w_res = r_mode ? w_win[DATA_W+1:2] : w_win[DATA_W-1:0];
    // A trailing odd column/row has an even index, so it never produces a window.
    w_out = valid_in & r_col[0] & r_row[0];
    w_fd  = w_out && (r_row == RW'(2 * NR - 1)) && (r_col == CW'(2 * NK - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_mode     <= 1'b0;
      r_pair     <= '0;
      o_data     <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (r_col == '0 && r_row == '0) r_mode <= mode;
        if (!r_col[0]) r_pair <= i_data;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_out) begin
          o_data     <= w_res;
          valid_out  <= 1'b1;
          frame_done <= w_fd;
        end
      end
    end
  end

  // Line buffer is not reset: every entry is rewritten on an even row before it is read.
  always_ff @(posedge clk) begin
    if (!rst && valid_in && r_col[0] && !r_row[0]) r_lb[w_k] <= w_pair;
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream: 6x6 signed instance and a 7x5 odd-size instance.
module tb_pool2d_stream;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_a, data_b;
  logic        valid_a, valid_b, mode_a, mode_b;
  logic [31:0] odata_a, odata_b;
  logic        vout_a, vout_b, fd_a, fd_b;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] last_a = 0;
  logic [31:0] last_b = 0;

  always #5 clk = ~clk;

  pool2d_stream #(.DATA_W(32), .IMG_W(6), .IMG_H(6), .SIGNED(1)) u_a (
    .clk(clk), .rst(rst), .i_data(data_a), .valid_in(valid_a), .mode(mode_a),
    .o_data(odata_a), .valid_out(vout_a), .frame_done(fd_a));

  pool2d_stream #(.DATA_W(32), .IMG_W(7), .IMG_H(5), .SIGNED(1)) u_b (
    .clk(clk), .rst(rst), .i_data(data_b), .valid_in(valid_b), .mode(mode_b),
    .o_data(odata_b), .valid_out(vout_b), .frame_done(fd_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic px_a(input logic [31:0] d, input logic m, input logic ev,
                      input logic [31:0] ed, input logic efd, input string tag);
    data_a = d; mode_a = m; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    if (ev) last_a = ed;
    chk({tag, "_vout"}, {31'd0, vout_a}, {31'd0, ev});
    chk({tag, "_data"}, odata_a, last_a);
    chk({tag, "_fd"}, {31'd0, fd_a}, {31'd0, efd});
  endtask

  task automatic idle_a(input string tag);
    valid_a = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_vout"}, {31'd0, vout_a}, 32'd0);
    chk({tag, "_idle_hold"}, odata_a, last_a);
  endtask

  task automatic px_b(input logic [31:0] d, input logic ev, input logic [31:0] ed,
                      input logic efd, input string tag);
    data_b = d; mode_b = 1'b0; valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
    if (ev) last_b = ed;
    chk({tag, "_vout"}, {31'd0, vout_b}, {31'd0, ev});
    chk({tag, "_data"}, odata_b, last_b);
    chk({tag, "_fd"}, {31'd0, fd_b}, {31'd0, efd});
  endtask

  // Ramp on the 6x6 instance: with a ramp, the window max is the bottom-right pixel p,
  // and the window sum is 4p-14, so the floored average is p-4.
  task automatic ramp_a(input int n, input logic m, input logic avg, input logic gap,
                        input string tag);
    for (int p = 0; p < n; p++) begin
      int r, c;
      logic v;
      r = p / 6; c = p % 6;
      v = (r % 2 == 1) && (c % 2 == 1);
      px_a(32'(p), (p == 0) ? m : ~m, v, avg ? 32'(p - 4) : 32'(p), p == 35, tag);
      if (gap) idle_a(tag);
    end
  endtask

  initial begin
    logic [31:0] sv [8];
    rst = 1'b1; valid_a = 0; valid_b = 0; mode_a = 0; mode_b = 0; data_a = 0; data_b = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_vout_a", {31'd0, vout_a}, 32'd0);
    chk("rst_fd_a",   {31'd0, fd_a},   32'd0);
    chk("rst_data_a", odata_a, 32'd0);
    chk("rst_vout_b", {31'd0, vout_b}, 32'd0);
    chk("rst_data_b", odata_b, 32'd0);
    rst = 1'b0;

    ramp_a(36, 1'b0, 1'b0, 1'b0, "max66");
    ramp_a(36, 1'b1, 1'b1, 1'b0, "avg66");
    ramp_a(36, 1'b0, 1'b0, 1'b1, "gap66");

    // Abort a frame mid-way; the sample presented during reset must be dropped.
    ramp_a(20, 1'b0, 1'b0, 1'b0, "part");
    rst = 1'b1; data_a = 32'd99; valid_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; valid_a = 1'b0; last_a = 0;
    chk("midrst_vout", {31'd0, vout_a}, 32'd0);
    chk("midrst_data", odata_a, 32'd0);
    chk("midrst_fd", {31'd0, fd_a}, 32'd0);
    ramp_a(36, 1'b0, 1'b0, 1'b0, "afterrst");

    // Signed windows, one frame start each, abandoned by reset.
    sv[0] = -32'sd5; sv[1] = -32'sd3; sv[2] = 0; sv[3] = 0; sv[4] = 0; sv[5] = 0;
    sv[6] = -32'sd8; sv[7] = -32'sd1;
    rst = 1'b1; @(negedge clk); rst = 1'b0; last_a = 0;
    for (int i = 0; i < 8; i++) px_a(sv[i], 1'b0, i == 7, 32'hFFFF_FFFF, 1'b0, "smax");
    sv[0] = -32'sd1; sv[1] = -32'sd2; sv[6] = -32'sd3; sv[7] = -32'sd4;
    rst = 1'b1; @(negedge clk); rst = 1'b0; last_a = 0;
    for (int i = 0; i < 8; i++) px_a(sv[i], 1'b1, i == 7, 32'hFFFF_FFFD, 1'b0, "savg");

    // 7x5: outputs 8,10,12,22,24,26; row 4 and column 6 never produce outputs.
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 35; p++) begin
        int r, c;
        r = p / 7; c = p % 7;
        px_b(32'(p), (r == 1 || r == 3) && (c % 2 == 1) && c < 6, 32'(p), p == 26,
             (f == 0) ? "odd75_f0" : "odd75_f1");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pool2d_stream.md
POOL2D_STREAM -- requirements
Module: pool2d_stream

Interface
REQ-001 Parameter DATA_W, default 32, bit width of each pixel sample.
REQ-002 Parameter IMG_W, default 6, input feature-map width in pixels (>=2).
REQ-003 Parameter IMG_H, default 6, input feature-map height in rows (>=2).
REQ-004 Parameter SIGNED, default 1, 1 = two's-complement comparison/averaging, 0 = unsigned.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 i_data  input  DATA_W  pixel sample, raster order (row-major, column 0 first).
REQ-008 valid_in  input  1  i_data is valid this cycle; gaps allowed, no backpressure.
REQ-009 mode  input  1  0 = max pooling, 1 = average pooling; sampled on first pixel of each frame.
REQ-010 o_data  output  DATA_W  pooled result.
REQ-011 valid_out  output  1  one-cycle strobe, o_data valid.
REQ-012 frame_done  output  1  one-cycle strobe coinciding with the last valid_out of a frame.

Function
REQ-013 Block SHALL perform 2x2 pooling, stride 2, on an IMG_W x IMG_H stream, producing (IMG_W/2) x (IMG_H/2) outputs (integer division) in raster order.
REQ-014 Column and row counters SHALL advance only on cycles with valid_in=1; idle cycles SHALL not alter state.
REQ-015 Even rows: each column pair (2k, 2k+1) SHALL be reduced (max, or DATA_W+1-bit sum) and stored in line-buffer entry k (IMG_W/2 entries).
REQ-016 Odd rows: each column pair SHALL be reduced and combined with line-buffer entry k to form the 2x2 result.
REQ-017 valid_out SHALL assert exactly one cycle after the clock edge accepting pixel (2r+1, 2k+1), i.e. latency 1 cycle from last window pixel.
REQ-018 Max mode: o_data SHALL equal the largest of the 4 window pixels under SIGNED comparison rules.
REQ-019 Average mode: 4-pixel sum SHALL be computed in DATA_W+2 bits (sign-extended if SIGNED) then arithmetically shifted right 2 (floor), truncated to DATA_W; no overflow possible.
REQ-020 Odd IMG_W: last column of each row SHALL be accepted and discarded; odd IMG_H: last row SHALL be accepted and discarded, no outputs.
REQ-021 After the last pixel of a frame (row IMG_H-1, column IMG_W-1) counters SHALL wrap to (0,0); next valid pixel begins a new frame with no dead cycle.
REQ-022 frame_done SHALL assert with the valid_out for window ((IMG_H/2)-1, (IMG_W/2)-1); for odd IMG_H, it SHALL assert at that same output, not at frame end.
REQ-023 mode SHALL be latched when valid_in=1 at (row 0, col 0); changes mid-frame SHALL have no effect until the next frame.
REQ-024 Back-to-back valid_in every cycle SHALL be sustained at full throughput with no dropped samples.
REQ-025 o_data SHALL hold its last value when valid_out=0.

Reset
REQ-026 On rst=1 at a clock edge: valid_out=0, frame_done=0, o_data=0, row/column counters=0, latched mode=0, pair registers cleared.
REQ-027 Reset mid-frame SHALL abandon the partial frame; the first valid pixel after rst deasserts SHALL be treated as (row 0, col 0).
REQ-028 rst SHALL take priority over valid_in in the same cycle; that sample is discarded.
REQ-029 Line-buffer contents need not be cleared; they SHALL never reach o_data before being rewritten in the current frame.

Verification
REQ-030 Max, 6x6, i_data=0..35 consecutive cycles -> 9 valid_out strobes, o_data 7,9,11,19,21,23,31,33,35; frame_done with 35.
REQ-031 Average, same ramp -> o_data 3,5,7,15,17,19,27,29,31.
REQ-032 SIGNED=1 max, window {-5,-3,-8,-1} -> o_data 0xFFFFFFFF; average window {-1,-2,-3,-4} -> 0xFFFFFFFD (-3, floor).
REQ-033 Ramp 0..35 with valid_in deasserted every other cycle -> same 9 values as REQ-030, each 1 cycle after its last window pixel.
REQ-034 rst pulsed after 20 pixels, then ramp 0..35 restarted -> no output from aborted frame after reset; outputs exactly as REQ-030.
REQ-035 IMG_W=7, IMG_H=5, ramp 0..34, max -> 6 outputs 8,10,12,22,24,26; row 4 and column 6 discarded; two frames back-to-back repeat identically.
